// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, constants and sign fixup for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Turns the unsigned iteration result into architectural HI/LO.
    // Multiply: data is the 64-bit magnitude product.
    // Divide: data is {remainder, quotient} magnitudes.
    function automatic hilo_t fix_result(
        input logic              is_div,
        input logic              neg_main,
        input logic              neg_rem,
        input logic              div_zero,
        input logic [2*XLEN-1:0] data
    );
        hilo_t             res;
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        quo = data[XLEN-1:0];
        rem = data[2*XLEN-1:XLEN];
        if (is_div) begin
            // Zero divisor leaves the dividend in the remainder field, so only LO needs forcing.
            res.lo = div_zero ? DIV0_LO : (neg_main ? -quo : quo);
            res.hi = neg_rem ? -rem : rem;
        end else begin
            prod   = neg_main ? -data : data;
            res.hi = prod[2*XLEN-1:XLEN];
            res.lo = prod[XLEN-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;

    // Shared shift register.
    // Multiply: sr[2W:W] accumulator, sr[W-1:0] multiplier shifting out / product low half shifting in.
    // Divide:   sr[2W:W] partial remainder, sr[W-1:0] dividend shifting out / quotient shifting in.
    logic [2*WIDTH:0] sr;
    logic [WIDTH-1:0] operand;     // multiplicand magnitude or divisor magnitude
    logic             is_div;
    logic             neg_main;
    logic             neg_rem;
    logic             div_zero;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift;
    logic             div_ok;
    logic [WIDTH:0]   div_rem;
    logic [2*WIDTH:0] sr_step;
    hilo_t            fixed;

    // Operand magnitudes and sign flags captured at launch.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One shift-add or restoring-divide iteration, plus the sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, sr[2*WIDTH-1:WIDTH]} + (sr[0] ? {1'b0, operand} : '0);
        div_shift = {sr[2*WIDTH:WIDTH], sr[WIDTH-1]};
        div_ok    = div_shift >= {2'b00, operand};
        div_rem   = div_ok ? (div_shift[WIDTH:0] - {1'b0, operand}) : div_shift[WIDTH:0];
        if (is_div) begin
            sr_step = {div_rem, sr[WIDTH-2:0], div_ok};
        end else begin
            sr_step = {1'b0, mul_sum, sr[WIDTH-1:1]};
        end
        fixed = fix_result(is_div, neg_main, neg_rem, div_zero, sr[2*WIDTH-1:0]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: launch, count down the iterations, then one fixup cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath, HI/LO and done pulse; MTHI/MTLO only take effect while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sr       <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div   <= op[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (b == '0);
                        operand  <= op[1] ? b_mag : a_mag;
                        sr       <= {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt      <= CNT_W'(ITER_COUNT);
                    end
                end
                CALC: begin
                    sr  <= sr_step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    hi   <= fixed.hi;
                    lo   <= fixed.lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking randomized bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      r64;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] q;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (m_op[1] && (y == 32'd0)) return {x, 32'hFFFF_FFFF};
        case (m_op)
            2'b00: begin r64 = sx * sy; return r64; end
            2'b01: return ux * uy;
            2'b10: begin
                r64 = sx / sy; q = r64;
                r64 = sx % sy; r = r64;
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ux / uy;
                r = ux % uy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Launch one operation and follow it to done; optionally pair it with MTHI at launch,
    // or poke start/MTLO mid-flight (both must be ignored).
    task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input bit with_hi_we, input bit inject);
        logic [63:0] exp;
        int          cycles;
        bit          stable;
        exp = model(t_op, t_a, t_b);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        if (with_hi_we) begin
            hi_we = 1'b1; wdata = 32'hA5A5_0001; m_hi = 32'hA5A5_0001;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        a = $urandom; b = $urandom;
        cycles = 0;
        stable = 1'b1;
        while (busy && cycles < 40) begin
            cycles++;
            if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
            if (inject && cycles == 5) begin
                start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
            end
            if (inject && cycles == 6) begin
                start = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 64'(cycles), 64'd33);
        chk({tag, ".hold"}, 64'(stable), 64'd1);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".hi"}, 64'(hi), 64'(exp[63:32]));
        chk({tag, ".lo"}, 64'(lo), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".idle_after"}, 64'(busy), 64'd0);
    endtask

    task automatic mt_write(input string tag, input bit hw, input bit lw, input logic [31:0] data);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = data;
        if (hw) m_hi = data;
        if (lw) m_lo = data;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    logic [31:0] corners [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};

    initial begin
        int          seen;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);

        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_op("div_by0_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        mt_write("mthi", 1'b1, 1'b0, 32'hDEAD_BEEF);
        mt_write("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
        mt_write("mtboth", 1'b1, 1'b1, 32'h1357_9BDF);

        run_op("ignored_in_busy", OP_MULT, 32'd1000, 32'hFFFF_FFFE, 1'b0, 1'b1);
        run_op("start_with_mthi", OP_DIVU, 32'd100, 32'd9, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) r_b = r_b & 32'h0000_00FF;
            run_op("rand", r_op, r_a, r_b, 1'b0, 1'b0);
        end

        // Abort a divide partway through with reset.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.hi", 64'(hi), 64'd0);
        chk("abort.lo", 64'(lo), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort.no_done", 64'(seen), 64'd0);
        run_op("after_reset_5x6", OP_MULT, 32'd5, 32'd6, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
